// File: rtl/seq_divider_64bit.sv
// Multi-cycle restoring divider: one quotient bit per clock via a WIDTH+1 bit trial subtraction.
// Define DIVIDER_SIGNED_EN to honour is_signed (truncating signed division with overflow flag).
module seq_divider_64bit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] div_mag;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             zero_div;
    logic             ovf_case;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             last;

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        a_neg    = is_signed & dividend[WIDTH-1];
        b_neg    = is_signed & divisor[WIDTH-1];
        ovf_case = is_signed && (dividend == MIN_VAL) && (divisor == '1);
    end
`else
    logic unused_signed;

    always_comb begin
        unused_signed = is_signed;
        a_neg         = 1'b0;
        b_neg         = 1'b0;
        ovf_case      = 1'b0;
    end
`endif

    always_comb begin
        zero_div = (divisor == '0);
        a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
    end

    // One restoring step; the borrow of the trial subtraction is the inverted quotient bit.
    always_comb begin
        shifted  = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
        trial    = {1'b0, shifted} - {1'b0, div_mag};
        rem_step = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
        q_step   = {q_r[WIDTH-2:0], ~trial[WIDTH]};
        q_final  = neg_q ? (~q_step + 1'b1) : q_step;
        r_final  = neg_r ? (~rem_step + 1'b1) : rem_step;
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (zero_div || ovf_case) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // Special cases finish straight from the accepting cycle; the sign fix-up rides on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            div_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                        end else if (ovf_case) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            cnt         <= '0;
                            rem_r       <= '0;
                            q_r         <= a_mag;
                            div_mag     <= b_mag;
                            neg_q       <= a_neg ^ b_neg;
                            neg_r       <= a_neg;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_step;
                    q_r   <= q_step;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        quotient  <= q_final;
                        remainder <= r_final;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_64bit.sv
// Randomised self-checking bench for seq_divider_64bit against a plain-arithmetic division model.
// Signed scenarios are exercised when DIVIDER_SIGNED_EN is defined.
module tb_seq_divider_64bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    seq_divider_64bit #(.WIDTH(64), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dbz, output logic ovf, output int lat);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        dbz = 1'b0;
        ovf = 1'b0;
        lat = 65;
        if (b == 64'd0) begin
            q = '1; r = a; dbz = 1'b1; lat = 1;
        end else if (SIGNED_EN && sgn) begin
            if (a == MIN64 && b == '1) begin
                q = MIN64; r = 64'd0; ovf = 1'b1; lat = 1;
            end else begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Starts an operation right after a falling edge and waits for done; ends on a falling edge.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                         output int lat, output int busy_cycles);
        dividend    = a;
        divisor     = b;
        is_signed   = sgn;
        start       = 1'b1;
        lat         = -1;
        busy_cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        vectors++; if (quotient !== 64'd0) begin errors++; $display("[TB] FAIL reset_quot got %h exp 0", quotient); end
        vectors++; if (remainder !== 64'd0) begin errors++; $display("[TB] FAIL reset_rem got %h exp 0", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got %b exp 0", div_by_zero); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [63:0] a_tab [4] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd12345};
        logic [63:0] b_tab [4] = '{64'd7, 64'd1, 64'd10, 64'd0};
        logic [63:0] eq, er;
        logic edbz, eovf;
        int elat, lat, bc;
        for (int i = 0; i < 4; i++) begin
            ref_div(a_tab[i], b_tab[i], 1'b0, eq, er, edbz, eovf, elat);
            do_op(a_tab[i], b_tab[i], 1'b0, lat, bc);
            vectors++; if (lat !== elat) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d exp %0d", i, lat, elat); end
            vectors++; if (bc !== elat - 1) begin errors++; $display("[TB] FAIL dir%0d_busy_cycles got %0d exp %0d", i, bc, elat - 1); end
            vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL dir%0d_quot got %h exp %h", i, quotient, eq); end
            vectors++; if (remainder !== er) begin errors++; $display("[TB] FAIL dir%0d_rem got %h exp %h", i, remainder, er); end
            vectors++; if (div_by_zero !== edbz) begin errors++; $display("[TB] FAIL dir%0d_dbz got %b exp %b", i, div_by_zero, edbz); end
            repeat (3) @(negedge clk);
            vectors++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_pulse got %b exp 0", i, done); end
            vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL dir%0d_hold_quot got %h exp %h", i, quotient, eq); end
        end
    endtask

    task automatic test_random;
        logic [63:0] a, b, eq, er;
        logic sgn, edbz, eovf;
        int elat, lat, bc;
        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) a = ~a;
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 2) == 0) b = ~b;
            if ($urandom_range(0, 9) == 0) b = 64'd0;
            sgn = 1'($urandom_range(0, 1));
            ref_div(a, b, sgn, eq, er, edbz, eovf, elat);
            do_op(a, b, sgn, lat, bc);
            vectors++; if (lat !== elat) begin errors++; $display("[TB] FAIL rnd%0d_latency got %0d exp %0d", i, lat, elat); end
            vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL rnd%0d_quot a=%h b=%h s=%b got %h exp %h", i, a, b, sgn, quotient, eq); end
            vectors++; if (remainder !== er) begin errors++; $display("[TB] FAIL rnd%0d_rem a=%h b=%h s=%b got %h exp %h", i, a, b, sgn, remainder, er); end
            vectors++; if ({div_by_zero, overflow} !== {edbz, eovf}) begin errors++; $display("[TB] FAIL rnd%0d_flags got %b%b exp %b%b", i, div_by_zero, overflow, edbz, eovf); end
        end
    endtask

    task automatic test_signed;
        logic [63:0] a_tab [5] = '{-64'sd7, 64'd7, MIN64, -64'sd99, MIN64};
        logic [63:0] b_tab [5] = '{64'd2, -64'sd2, '1, 64'd0, 64'd3};
        logic [63:0] eq, er;
        logic edbz, eovf;
        int elat, lat, bc;
        for (int i = 0; i < 5; i++) begin
            ref_div(a_tab[i], b_tab[i], 1'b1, eq, er, edbz, eovf, elat);
            do_op(a_tab[i], b_tab[i], 1'b1, lat, bc);
            vectors++; if (lat !== elat) begin errors++; $display("[TB] FAIL sgn%0d_latency got %0d exp %0d", i, lat, elat); end
            vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL sgn%0d_quot got %h exp %h", i, quotient, eq); end
            vectors++; if (remainder !== er) begin errors++; $display("[TB] FAIL sgn%0d_rem got %h exp %h", i, remainder, er); end
            vectors++; if ({div_by_zero, overflow} !== {edbz, eovf}) begin errors++; $display("[TB] FAIL sgn%0d_flags got %b%b exp %b%b", i, div_by_zero, overflow, edbz, eovf); end
        end
    endtask

    task automatic test_start_ignored;
        logic [63:0] eq, er;
        logic edbz, eovf;
        int elat, lat;
        ref_div(64'd1_000_003, 64'd17, 1'b0, eq, er, edbz, eovf, elat);
        dividend = 64'd1_000_003; divisor = 64'd17; is_signed = 1'b0; start = 1'b1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) begin
                dividend = 64'd77; divisor = 64'd0; start = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        vectors++; if (lat !== elat) begin errors++; $display("[TB] FAIL ignore_latency got %0d exp %0d", lat, elat); end
        vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL ignore_quot got %h exp %h", quotient, eq); end
        vectors++; if (remainder !== er) begin errors++; $display("[TB] FAIL ignore_rem got %h exp %h", remainder, er); end
        vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL ignore_dbz got %b exp 0", div_by_zero); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] eq, er;
        logic edbz, eovf;
        int elat, lat, bc;
        do_op(64'd999, 64'd10, 1'b0, lat, bc);
        ref_div(64'd123_456_789, 64'd1000, 1'b0, eq, er, edbz, eovf, elat);
        vectors++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done got %b exp 1", done); end
        do_op(64'd123_456_789, 64'd1000, 1'b0, lat, bc);
        vectors++; if (lat !== elat) begin errors++; $display("[TB] FAIL b2b_latency got %0d exp %0d", lat, elat); end
        vectors++; if (quotient !== eq) begin errors++; $display("[TB] FAIL b2b_quot got %h exp %h", quotient, eq); end
        vectors++; if (remainder !== er) begin errors++; $display("[TB] FAIL b2b_rem got %h exp %h", remainder, er); end
    endtask

    task automatic test_reset_abort;
        int seen;
        dividend = 64'd5555; divisor = 64'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b exp 0", busy); end
        vectors++; if (quotient !== 64'd0) begin errors++; $display("[TB] FAIL abort_quot got %h exp 0", quotient); end
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vectors++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_activity got %0d exp 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_signed();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
